// File: rtl/dsp_tone_detector.sv
`default_nettype none
// ============================================================================
// Module   : dsp_tone_detector
// Brief    : Moving-average smoother, hysteresis thresholds and a
//            consecutive-frame debounce on Goertzel magnitudes. Produces a
//            clean tone_present level plus tone_rise / tone_fall pulses.
// Options  : TONE_PEAK_HOLD_EN - when defined, peak_mag holds the largest
//            average seen while the tone is present; otherwise peak_mag is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_tone_detector #(
  parameter int MAG_W      = 16,
  parameter int AVG_LEN    = 4,
  parameter int AVG_BITS   = 2,
  parameter int ON_THRESH  = 1000,
  parameter int OFF_THRESH = 600,
  parameter int HOLD_CNT   = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             mag_rdy,
  input  logic [MAG_W-1:0] goertzel_mag,
  output logic [MAG_W-1:0] avg_mag,
  output logic             avg_valid,
  output logic             tone_present,
  output logic             tone_rise,
  output logic             tone_fall,
  output logic [MAG_W-1:0] peak_mag
);

  // Running sum is wide enough to hold AVG_LEN full-scale samples.
  localparam int SUM_W  = MAG_W + AVG_BITS;
  // The pointer keeps at least one bit so AVG_LEN == 1 stays legal; the
  // ring is sized to the pointer range so every index is in bounds.
  localparam int PTR_W  = (AVG_BITS > 0) ? AVG_BITS : 1;
  localparam int DEPTH  = 1 << PTR_W;
  localparam int FILL_W = AVG_BITS + 1;

  localparam logic [PTR_W-1:0]  c_PTR_LAST  = PTR_W'(AVG_LEN - 1);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(AVG_LEN);
  localparam logic [MAG_W-1:0]  c_ON        = MAG_W'(ON_THRESH);
  localparam logic [MAG_W-1:0]  c_OFF       = MAG_W'(OFF_THRESH);
  localparam logic [3:0]        c_HOLD      = 4'(HOLD_CNT);

  typedef enum logic [1:0] {
    QUIET     = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } state_t;

  // ---------------------------------------------------------------- averaging
  logic [MAG_W-1:0]  buf_q [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [MAG_W-1:0]  avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;

  // Replace the oldest sample in the window and derive the new average.
  always_comb begin
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (mag_rdy) begin
      sum_d       = sum_q - SUM_W'(buf_q[ptr_q]) + SUM_W'(goertzel_mag);
      ptr_d       = (ptr_q == c_PTR_LAST) ? '0 : ptr_q + 1'b1;
      fill_d      = (fill_q == c_FILL_FULL) ? fill_q : fill_q + 1'b1;
      avg_d       = sum_d[SUM_W-1:AVG_BITS];
      avg_valid_d = (fill_d == c_FILL_FULL);
    end
  end

  // Window storage, running sum and average registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      sum_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      if (mag_rdy) begin
        buf_q[ptr_q] <= goertzel_mag;
      end
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  // ---------------------------------------------------------------- detection
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       present_q, present_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Hysteresis/debounce decision, taken once per full-window average.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    present_d = present_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (avg_valid_q) begin
      case (state_q)
        QUIET: begin
          if (avg_q >= c_ON) begin
            if (c_HOLD == 4'd1) begin
              state_d   = ACTIVE;
              cnt_d     = '0;
              present_d = 1'b1;
              rise_d    = 1'b1;
            end else begin
              state_d = ARMING;
              cnt_d   = 4'd1;
            end
          end
        end
        ARMING: begin
          if (avg_q >= c_ON) begin
            if ((cnt_q + 4'd1) == c_HOLD) begin
              state_d   = ACTIVE;
              cnt_d     = '0;
              present_d = 1'b1;
              rise_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = QUIET;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          if (avg_q < c_OFF) begin
            if (c_HOLD == 4'd1) begin
              state_d   = QUIET;
              cnt_d     = '0;
              present_d = 1'b0;
              fall_d    = 1'b1;
            end else begin
              state_d = RELEASING;
              cnt_d   = 4'd1;
            end
          end
        end
        RELEASING: begin
          if (avg_q < c_OFF) begin
            if ((cnt_q + 4'd1) == c_HOLD) begin
              state_d   = QUIET;
              cnt_d     = '0;
              present_d = 1'b0;
              fall_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d   = QUIET;
          cnt_d     = '0;
          present_d = 1'b0;
        end
      endcase
    end
  end

  // Detection state and event registers; reset never emits a fall pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= QUIET;
      cnt_q     <= '0;
      present_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      present_q <= present_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // --------------------------------------------------------------- peak hold
`ifdef TONE_PEAK_HOLD_EN
  logic [MAG_W-1:0] peak_q, peak_d;

  // Seed with the average that caused the rise, then track the maximum.
  always_comb begin
    peak_d = peak_q;
    if (rise_d) begin
      peak_d = avg_q;
    end else if (present_q && (avg_q > peak_q)) begin
      peak_d = avg_q;
    end
  end

  // Peak register; keeps its value after the tone falls.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_mag = peak_q;
`else
  assign peak_mag = '0;
`endif

  assign avg_mag      = avg_q;
  assign avg_valid    = avg_valid_q;
  assign tone_present = present_q;
  assign tone_rise    = rise_q;
  assign tone_fall    = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_tone_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_tone_detector
// Brief    : Self-checking bench for dsp_tone_detector. A queue-based window
//            and a run-length level model predict every output each cycle;
//            directed steps cover fill, hysteresis, saturation and reset.
//            A second instance uses AVG_LEN=1.
// Options  : TONE_PEAK_HOLD_EN changes the expected peak_mag values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_tone_detector;

  localparam int MAG_W  = 16;
  localparam int AVG_LEN = 4;
  localparam int ON_T   = 1000;
  localparam int OFF_T  = 600;
  localparam int HOLD   = 3;
`ifdef TONE_PEAK_HOLD_EN
  localparam int PEAK_MAIN = 2000;
  localparam int PEAK_LEN1 = 1500;
`else
  localparam int PEAK_MAIN = 0;
  localparam int PEAK_LEN1 = 0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             mag_rdy;
  logic [MAG_W-1:0] goertzel_mag;
  logic [MAG_W-1:0] avg_mag, peak_mag;
  logic             avg_valid, tone_present, tone_rise, tone_fall;

  logic             s_rdy;
  logic [MAG_W-1:0] s_mag;
  logic [MAG_W-1:0] s_avg, s_peak;
  logic             s_valid, s_present, s_rise, s_fall;

  always #5 sys_clk = ~sys_clk;

  dsp_tone_detector #(
    .MAG_W(MAG_W), .AVG_LEN(4), .AVG_BITS(2),
    .ON_THRESH(ON_T), .OFF_THRESH(OFF_T), .HOLD_CNT(HOLD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mag_rdy(mag_rdy),
    .goertzel_mag(goertzel_mag), .avg_mag(avg_mag), .avg_valid(avg_valid),
    .tone_present(tone_present), .tone_rise(tone_rise),
    .tone_fall(tone_fall), .peak_mag(peak_mag)
  );

  dsp_tone_detector #(
    .MAG_W(MAG_W), .AVG_LEN(1), .AVG_BITS(0),
    .ON_THRESH(ON_T), .OFF_THRESH(OFF_T), .HOLD_CNT(HOLD)
  ) dut_len1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mag_rdy(s_rdy),
    .goertzel_mag(s_mag), .avg_mag(s_avg), .avg_valid(s_valid),
    .tone_present(s_present), .tone_rise(s_rise),
    .tone_fall(s_fall), .peak_mag(s_peak)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: window of recent samples and a detected level with a
  // count of consecutive frames that argue for flipping it.
  int win[$];
  int m_avg, m_peak, m_run;
  bit m_valid, m_level, m_present, m_rise, m_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  s;
    bit  qual, nrise, nfall;
    if (sys_rst) begin
      win.delete();
      m_avg = 0; m_valid = 0; m_level = 0; m_present = 0;
      m_rise = 0; m_fall = 0; m_run = 0; m_peak = 0;
      return;
    end
    nrise = 0;
    nfall = 0;
    if (m_valid) begin
      qual  = m_level ? (m_avg < OFF_T) : (m_avg >= ON_T);
      m_run = qual ? m_run + 1 : 0;
      if (m_run == HOLD) begin
        m_level = !m_level;
        m_run   = 0;
        nrise   = m_level;
        nfall   = !m_level;
      end
    end
`ifdef TONE_PEAK_HOLD_EN
    if (m_present && (m_avg > m_peak)) m_peak = m_avg;
    if (nrise) m_peak = m_avg;
`endif
    m_valid = 0;
    if (mag_rdy) begin
      win.push_back(int'(goertzel_mag));
      if (win.size() > AVG_LEN) void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
      m_avg   = s / AVG_LEN;
      m_valid = (win.size() == AVG_LEN);
    end
    m_present = m_level;
    m_rise    = nrise;
    m_fall    = nfall;
  endtask

  task automatic check_all();
    chk("avg_mag",      avg_mag,      m_avg);
    chk("avg_valid",    avg_valid,    m_valid);
    chk("tone_present", tone_present, m_present);
    chk("tone_rise",    tone_rise,    m_rise);
    chk("tone_fall",    tone_fall,    m_fall);
    chk("peak_mag",     peak_mag,     m_peak);
  endtask

  // Drive one clock of inputs, advance the model, check after the edge.
  task automatic cycle(input bit rst_v, input bit rdy_v, input int mag_v);
    sys_rst      = rst_v;
    mag_rdy      = rdy_v;
    goertzel_mag = MAG_W'(mag_v);
    model_step();
    @(negedge sys_clk);
    check_all();
  endtask

  initial begin
    int e800 [4];
    int ezero[4];
    int len1 [6];
    int v;
    bit hi, rdy, r;
    e800  = '{1700, 1400, 1100, 800};
    ezero = '{600, 400, 200, 0};
    len1  = '{1500, 1500, 500, 1500, 1500, 1500};
    sys_rst = 1'b1; mag_rdy = 1'b0; goertzel_mag = '0;
    s_rdy = 1'b0; s_mag = '0;

    // Reset and idle: everything quiet.
    repeat (3) cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    chk("idle_avg", avg_mag, 0);
    chk("idle_present", tone_present, 0);
    chk("idle_peak", peak_mag, 0);
    chk("idle_len1_avg", s_avg, 0);

    // Three samples never fill the window.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 2000);
      chk("partial_valid", avg_valid, 0);
      cycle(0, 0, 0);
    end
    repeat (5) cycle(0, 0, 0);

    // Fresh fill with 2000: valid from sample 4, rise two cycles after sample 6.
    cycle(1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, 2000);
      chk("fill_valid", avg_valid, (i >= 4) ? 1 : 0);
      if (i >= 4) chk("fill_avg", avg_mag, 2000);
      cycle(0, 0, 0);
      chk("rise_timing", tone_rise, (i == 6) ? 1 : 0);
      cycle(0, 0, 0);
    end
    repeat (4) cycle(0, 0, 0);
    chk("hold_present", tone_present, 1);

    // Mid-band averages keep the tone; zeros release it after three frames.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 800);
      chk("mid_avg", avg_mag, e800[i]);
      cycle(0, 0, 0);
      chk("mid_present", tone_present, 1);
      cycle(0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0);
      chk("zero_avg", avg_mag, ezero[i]);
      cycle(0, 0, 0);
      chk("fall_timing", tone_fall, (i == 3) ? 1 : 0);
      chk("fall_present", tone_present, (i == 3) ? 0 : 1);
      cycle(0, 0, 0);
    end
    chk("peak_after_fall", peak_mag, PEAK_MAIN);

    // Single-frame window: an intervening low frame restarts the debounce.
    for (int i = 0; i < 6; i++) begin
      s_rdy = 1'b1;
      s_mag = MAG_W'(len1[i]);
      cycle(0, 0, 0);
      s_rdy = 1'b0;
      chk("len1_avg", s_avg, len1[i]);
      chk("len1_valid", s_valid, 1);
      cycle(0, 0, 0);
      chk("len1_rise", s_rise, (i == 5) ? 1 : 0);
      cycle(0, 0, 0);
    end
    chk("len1_present", s_present, 1);
    chk("len1_fall", s_fall, 0);
    chk("len1_peak", s_peak, PEAK_LEN1);

    // Full-scale samples back to back: no overflow, valid every cycle.
    cycle(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 65535);
      chk("fs_valid", avg_valid, (i >= 3) ? 1 : 0);
      if (i >= 3) chk("fs_avg", avg_mag, 65535);
    end
    repeat (3) cycle(0, 0, 0);
    chk("fs_present", tone_present, 1);

    // Reset while active, with a sample offered in the same cycle.
    cycle(1, 1, 2000);
    chk("rst_present", tone_present, 0);
    chk("rst_fall", tone_fall, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_avg", avg_mag, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 300);
      chk("refill_valid", avg_valid, (i == 4) ? 1 : 0);
      cycle(0, 0, 0);
    end

    // Randomized segments alternating between loud and quiet bands.
    for (int seg = 0; seg < 30; seg++) begin
      hi = ($urandom_range(0, 1) == 1);
      repeat (15) begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) v = 65535;
        else if (hi) v = int'($urandom_range(900, 2500));
        else v = int'($urandom_range(0, 700));
        r = ($urandom_range(0, 199) == 0);
        cycle(r, rdy, v);
      end
    end
    repeat (4) cycle(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
